// File: rtl/sample_source_if.sv
// rtl/sample_source_if.sv - sample strobe interface from the test source to the filter
interface sample_source_if #(
  parameter int WIDTH = 20
);
  logic signed [WIDTH-1:0] sample_sig;
  logic                    ready;

  modport master (output sample_sig, output ready);
  modport slave  (input sample_sig, input ready);
endinterface

// File: rtl/sample_source.sv
// rtl/sample_source.sv - paced burst generator: impulse, triangles and LFSR noise
module sample_source #(
  parameter int WIDTH       = 20,
  parameter int DIV         = 128,
  parameter int NUM_SAMPLES = 800,
  parameter int STEP_A      = 1024,
  parameter int AMP_A       = 8192,
  parameter int STEP_B      = 4096,
  parameter int AMP_B       = 65536,
  parameter int NOISE_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  sample_source_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic [16:0]            sample_idx
);
  localparam int SW = WIDTH + 2;
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0]        DIV_LAST = DW'(DIV - 1);
  localparam logic signed [SW-1:0] SAT_MAX  = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN  = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] ST_A = SW'(STEP_A);
  localparam logic signed [SW-1:0] AM_A = SW'(AMP_A);
  localparam logic signed [SW-1:0] ST_B = SW'(STEP_B);
  localparam logic signed [SW-1:0] AM_B = SW'(AMP_B);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [DW-1:0]          div_cnt;
  logic [1:0]             mode_q;
  logic signed [SW-1:0]   ta, tb, ta_n, tb_n, noise, sum;
  logic                   ta_up, tb_up, ta_up_n, tb_up_n, imp_flag;
  logic [15:0]            lfsr, lfsr_n;
  logic signed [WIDTH-1:0] sample_n;
  logic                   tick, last, accept;

  // Returns {direction_up, value}; reflects off the peak instead of clipping.
  function automatic logic [SW:0] tri_step(input logic signed [SW-1:0] t, input logic up,
                                           input logic signed [SW-1:0] step,
                                           input logic signed [SW-1:0] amp);
    if (up) begin
      if (t + step > amp) return {1'b0, t - step};
      else                return {1'b1, t + step};
    end else begin
      if (t - step < -amp) return {1'b1, t + step};
      else                 return {1'b0, t - step};
    end
  endfunction

  assign tick   = (state == S_RUN) && (div_cnt == DIV_LAST);
  assign last   = tick && (sample_idx == 17'(NUM_SAMPLES - 1));
  assign accept = start && (state != S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_comb begin
    {ta_up_n, ta_n} = tri_step(ta, ta_up, ST_A, AM_A);
    {tb_up_n, tb_n} = tri_step(tb, tb_up, ST_B, AM_B);
    lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    noise  = SW'($signed(lfsr_n[NOISE_BITS-1:0]));
    sum    = ((mode_q != 2'd0) ? ta_n : '0) + (mode_q[1] ? tb_n : '0)
           + ((mode_q == 2'd3) ? noise : '0);
    if (mode_q == 2'd0)   sample_n = imp_flag ? SAT_MAX[WIDTH-1:0] : '0;
    else if (sum > SAT_MAX) sample_n = SAT_MAX[WIDTH-1:0];
    else if (sum < SAT_MIN) sample_n = SAT_MIN[WIDTH-1:0];
    else                    sample_n = sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt        <= '0;
      sample_idx     <= '0;
      mode_q         <= '0;
      ta             <= '0;
      tb             <= '0;
      ta_up          <= 1'b1;
      tb_up          <= 1'b1;
      lfsr           <= 16'hACE1;
      imp_flag       <= 1'b0;
      bus.sample_sig <= '0;
      bus.ready      <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      if (accept) begin
        div_cnt        <= '0;
        sample_idx     <= '0;
        mode_q         <= mode;
        ta             <= '0;
        tb             <= '0;
        ta_up          <= 1'b1;
        tb_up          <= 1'b1;
        lfsr           <= 16'hACE1;
        imp_flag       <= 1'b1;
        bus.sample_sig <= '0;
      end else if (state == S_RUN) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) begin
          ta             <= ta_n;
          tb             <= tb_n;
          ta_up          <= ta_up_n;
          tb_up          <= tb_up_n;
          lfsr           <= lfsr_n;
          imp_flag       <= 1'b0;
          bus.sample_sig <= sample_n;
          bus.ready      <= 1'b1;
          sample_idx     <= sample_idx + 17'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sample_source.sv
// tb/tb_sample_source.sv - directed self-checking bench for sample_source
module tb_sample_source;
  localparam int W = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
  logic busy_a, done_a, busy_b, done_b;
  logic [16:0] idx_a, idx_b;

  sample_source_if #(.WIDTH(W)) bus_a ();
  sample_source_if #(.WIDTH(W)) bus_b ();

  int compared = 0;
  int mismatched = 0;
  int cycle_cnt = 0;
  int e0_cyc = 0;

  logic signed [W-1:0] cap_s [0:31];
  logic [16:0]         cap_i [0:31];
  logic                cap_d [0:31];
  logic                cap_b [0:31];
  int                  cap_t [0:31];

  int exp_tri [0:11] = '{1024, 2048, 3072, 4096, 5120, 6144, 7168, 8192, 7168, 6144, 5120, 4096};
  int exp_noise [0:2] = '{5232, 10296, 15260};
  int sat_pos [0:7] = '{0, 1, 2, 5, 9, 13, 21, 23};
  int sat_val [0:7] = '{263168, 524287, 265216, -518144, 524287, -522240, -524288, -8192};

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  sample_source #(.WIDTH(W), .DIV(4), .NUM_SAMPLES(12)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .sample_idx(idx_a)
  );

  sample_source #(.WIDTH(W), .DIV(4), .NUM_SAMPLES(24), .STEP_B(262144), .AMP_B(524288)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .sample_idx(idx_b)
  );

  task automatic start_burst(input bit sel, input logic [1:0] m);
    @(negedge clk);
    if (sel) begin start_b = 1'b1; mode_b = m; end
    else     begin start_a = 1'b1; mode_a = m; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    e0_cyc = cycle_cnt;
  endtask

  task automatic capture(input bit sel, input int base, input int n);
    for (int k = base; k < base + n; k++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!(sel ? bus_b.ready : bus_a.ready) && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (!(sel ? bus_b.ready : bus_a.ready)) begin
        compared++;
        mismatched++;
        $display("FAIL capture_timeout strobe %0d: ready=0 after 40 cycles, required 1", k + 1);
        return;
      end
      cap_s[k] = sel ? bus_b.sample_sig : bus_a.sample_sig;
      cap_i[k] = sel ? idx_b : idx_a;
      cap_d[k] = sel ? done_b : done_a;
      cap_b[k] = sel ? busy_b : busy_a;
      cap_t[k] = cycle_cnt;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared += 6;
    if (bus_a.sample_sig !== '0) begin mismatched++; $display("FAIL reset_sample got %0d want 0", bus_a.sample_sig); end
    if (bus_a.ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got %b want 0", bus_a.ready); end
    if (busy_a !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy_a); end
    if (done_a !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done_a); end
    if (idx_a !== 17'd0) begin mismatched++; $display("FAIL reset_idx got %0d want 0", idx_a); end
    if ({bus_b.ready, busy_b, done_b, idx_b, bus_b.sample_sig} !== '0) begin
      mismatched++; $display("FAIL reset_dut_b got nonzero outputs, want all 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_tri_a;
    start_burst(1'b0, 2'd1);
    compared++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      mismatched++; $display("FAIL tri_start busy=%b done=%b want busy=1 done=0", busy_a, done_a);
    end
    capture(1'b0, 0, 12);
    for (int k = 0; k < 12; k++) begin
      compared += 3;
      if (cap_s[k] !== exp_tri[k]) begin mismatched++; $display("FAIL tri_sample %0d got %0d want %0d", k + 1, cap_s[k], exp_tri[k]); end
      if (cap_i[k] !== 17'(k + 1)) begin mismatched++; $display("FAIL tri_idx %0d got %0d want %0d", k + 1, cap_i[k], k + 1); end
      if ((k == 0 ? cap_t[0] - e0_cyc : cap_t[k] - cap_t[k-1]) !== 4) begin
        mismatched++; $display("FAIL tri_spacing %0d got %0d cycles want 4", k + 1, k == 0 ? cap_t[0] - e0_cyc : cap_t[k] - cap_t[k-1]);
      end
    end
    compared += 2;
    if (cap_d[11] !== 1'b1 || cap_b[11] !== 1'b0) begin
      mismatched++; $display("FAIL tri_last_flags done=%b busy=%b want done=1 busy=0", cap_d[11], cap_b[11]);
    end
    if (cap_d[10] !== 1'b0) begin mismatched++; $display("FAIL tri_early_done got %b want 0", cap_d[10]); end
    repeat (6) @(negedge clk);
    compared++;
    if (bus_a.sample_sig !== 20'sd4096 || done_a !== 1'b1 || bus_a.ready !== 1'b0) begin
      mismatched++; $display("FAIL tri_hold sample=%0d done=%b ready=%b want 4096/1/0", bus_a.sample_sig, done_a, bus_a.ready);
    end
  endtask

  task automatic test_impulse;
    start_burst(1'b0, 2'd0);
    compared++;
    if (bus_a.sample_sig !== '0 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      mismatched++; $display("FAIL imp_restart sample=%0d busy=%b done=%b want 0/1/0", bus_a.sample_sig, busy_a, done_a);
    end
    capture(1'b0, 0, 12);
    for (int k = 0; k < 12; k++) begin
      compared++;
      if (cap_s[k] !== (k == 0 ? 524287 : 0)) begin
        mismatched++; $display("FAIL imp_sample %0d got %0d want %0d", k + 1, cap_s[k], k == 0 ? 524287 : 0);
      end
    end
    compared++;
    if (cap_d[11] !== 1'b1 || cap_b[11] !== 1'b0 || cap_i[11] !== 17'd12) begin
      mismatched++; $display("FAIL imp_end done=%b busy=%b idx=%0d want 1/0/12", cap_d[11], cap_b[11], cap_i[11]);
    end
  endtask

  task automatic test_noise;
    for (int r = 0; r < 2; r++) begin
      start_burst(1'b0, 2'd3);
      capture(1'b0, 0, 12);
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (cap_s[k] !== exp_noise[k]) begin
          mismatched++; $display("FAIL noise_run%0d sample %0d got %0d want %0d", r, k + 1, cap_s[k], exp_noise[k]);
        end
      end
      compared++;
      if (cap_i[11] !== 17'd12 || cap_d[11] !== 1'b1) begin
        mismatched++; $display("FAIL noise_run%0d end idx=%0d done=%b want 12/1", r, cap_i[11], cap_d[11]);
      end
    end
  endtask

  task automatic test_saturation;
    start_burst(1'b1, 2'd2);
    capture(1'b1, 0, 24);
    for (int k = 0; k < 8; k++) begin
      compared++;
      if (cap_s[sat_pos[k]] !== sat_val[k]) begin
        mismatched++; $display("FAIL sat_sample %0d got %0d want %0d", sat_pos[k] + 1, cap_s[sat_pos[k]], sat_val[k]);
      end
    end
    compared++;
    if (cap_d[23] !== 1'b1 || cap_i[23] !== 17'd24) begin
      mismatched++; $display("FAIL sat_end done=%b idx=%0d want 1/24", cap_d[23], cap_i[23]);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    start_burst(1'b0, 2'd1);
    capture(1'b0, 0, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({bus_a.ready, busy_a, done_a, idx_a, bus_a.sample_sig} !== '0) begin
      mismatched++; $display("FAIL rst_async sample=%0d idx=%0d busy=%b done=%b ready=%b want all 0",
                             bus_a.sample_sig, idx_a, busy_a, done_a, bus_a.ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_a.ready) seen = 1;
    end
    compared++;
    if (seen !== 0) begin mismatched++; $display("FAIL rst_no_strobe got ready seen=%0d want 0", seen); end
    start_burst(1'b0, 2'd1);
    capture(1'b0, 0, 12);
    compared += 2;
    if (cap_t[0] - e0_cyc !== 4 || cap_s[0] !== 20'sd1024) begin
      mismatched++; $display("FAIL rst_first_strobe latency=%0d sample=%0d want 4/1024", cap_t[0] - e0_cyc, cap_s[0]);
    end
    if (cap_i[11] !== 17'd12 || cap_d[11] !== 1'b1) begin
      mismatched++; $display("FAIL rst_rerun_end idx=%0d done=%b want 12/1", cap_i[11], cap_d[11]);
    end
  endtask

  task automatic test_start_ignored;
    start_burst(1'b0, 2'd1);
    capture(1'b0, 0, 2);
    @(negedge clk);
    start_a = 1'b1; mode_a = 2'd0;
    @(negedge clk);
    mode_a = 2'd3;
    @(negedge clk);
    start_a = 1'b0; mode_a = 2'd2;
    compared++;
    if (busy_a !== 1'b1 || idx_a !== 17'd2) begin
      mismatched++; $display("FAIL ign_state busy=%b idx=%0d want 1/2", busy_a, idx_a);
    end
    capture(1'b0, 2, 10);
    compared += 4;
    if (cap_t[2] - cap_t[1] !== 4) begin mismatched++; $display("FAIL ign_spacing got %0d want 4", cap_t[2] - cap_t[1]); end
    if (cap_s[2] !== 20'sd3072) begin mismatched++; $display("FAIL ign_sample3 got %0d want 3072", cap_s[2]); end
    if (cap_s[11] !== 20'sd4096) begin mismatched++; $display("FAIL ign_sample12 got %0d want 4096", cap_s[11]); end
    if (cap_i[11] !== 17'd12 || cap_d[11] !== 1'b1) begin
      mismatched++; $display("FAIL ign_end idx=%0d done=%b want 12/1", cap_i[11], cap_d[11]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tri_a();
    test_impulse();
    test_noise();
    test_saturation();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sample_source.md
# sample_source

Programmable test-signal transmitter that drives the FIR wrapper's sample interface (`input_sig`, `ready`). It paces samples with a clock divider and emits one-cycle `ready` strobes with a held signed sample. It produces a fixed-length burst of impulse, triangle, dual-triangle or dual-triangle-plus-noise stimulus. It sits at the front of the filter test harness, the transmitting end of the interface the filter sockets consume.

## Interface
- `WIDTH`, 20: sample width, signed two's complement.
- `DIV`, 128: clock cycles per sample; must be ≥ 2.
- `NUM_SAMPLES`, 800: strobes per burst; must be ≥ 1 and < 2^17.
- `STEP_A`, 1024: triangle A step per sample.
- `AMP_A`, 8192: triangle A peak magnitude.
- `STEP_B`, 4096: triangle B step per sample.
- `AMP_B`, 65536: triangle B peak magnitude.
- `NOISE_BITS`, 8: LFSR bits used as signed noise.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin burst; sampled in IDLE or DONE only.
- `mode`  in  2  0 impulse, 1 tri A, 2 tri A+B, 3 tri A+B+noise; latched when `start` is accepted.
- `sample_sig`  out  WIDTH  current sample, signed; held between strobes.
- `ready`  out  1  one-cycle strobe: a new `sample_sig` is valid.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `sample_idx`  out  17  number of strobes issued in the current burst.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DONE on the edge issuing strobe number NUM_SAMPLES.
  - DONE → RUN on `start`.
  - `start` is ignored in RUN.
- On entering RUN, the block clears:
  - `div_cnt` to 0;
  - `sample_idx` to 0;
  - tri A and tri B to 0, both direction up;
  - the LFSR, reloaded with 16'hACE1;
  - the impulse flag, which is set;
  - `sample_sig`, to 0.
- `div_cnt` increments each RUN cycle and wraps at DIV-1. On the edge where `div_cnt == DIV-1`, a sample event occurs.
- Each sample event:
  - updates all generators;
  - loads `sample_sig`;
  - sets `ready` for exactly one cycle;
  - increments `sample_idx`.
- Triangle update, shown for A (B is identical with STEP_B/AMP_B):
  - Going up: if t+STEP_A > AMP_A then t ← t−STEP_A and the direction flips to down; otherwise t ← t+STEP_A.
  - Going down: if t−STEP_A < −AMP_A then t ← t+STEP_A and the direction flips to up; otherwise t ← t−STEP_A.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts once per sample event. Noise is the low NOISE_BITS bits, sign-extended.
- Impulse mode: the first sample is 2^(WIDTH−1)−1 and all later samples are 0.
- Other modes: the output is the sum of the enabled terms using the updated generator values.
  - The sum is computed at WIDTH+2 bits.
  - It is saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Generators update in every mode. Only the selected terms are summed.

## Timing
- Reset values: `sample_sig`=0, `ready`=0, `busy`=0, `done`=0, `sample_idx`=0. State IDLE, `div_cnt`=0.
- Reset is asynchronous. Asserted mid-burst, it aborts at once with no further strobes.
- `start` accepted at edge E0: `busy`=1 after E0.
- First `ready` is high in the cycle after edge E0+DIV.
- Strobes are exactly DIV cycles apart.
- `sample_sig` changes only on strobe edges. It holds the last value in DONE and is cleared on the next accepted `start`.
- On the final strobe edge, `ready`=1, `sample_idx`=NUM_SAMPLES, `busy`=0 and `done`=1, all in the same cycle.
- A `start` held high across DONE restarts on the first DONE-cycle edge. That is at least one cycle after the final strobe.
- `mode` changes during RUN have no effect until the next accepted `start`.

## Test plan
- Reset, then mode 1, DIV=4, NUM_SAMPLES=12, `start` one cycle:
  - `ready` every 4 cycles;
  - samples 1024, 2048, …, 8192, then 7168, 6144, 5120, 4096;
  - `done`=1 and `sample_idx`=12 with the last strobe.
- Mode 0, NUM_SAMPLES=5:
  - samples 524287, 0, 0, 0, 0;
  - then `busy`=0 and `done`=1.
- Mode 2 with AMP_B=2^19 and STEP_B=2^18:
  - the sum exceeds 524287;
  - the output saturates to exactly 524287 (and −524288 on the negative excursion);
  - no wrap.
- Mode 3: the first three noise terms match a reference LFSR from seed 16'hACE1. Restarting from DONE reproduces an identical sequence.
- Assert `rst` between strobes 3 and 4:
  - all outputs are 0 immediately;
  - no strobe follows;
  - a new `start` gives its first strobe DIV cycles later.
- Pulse `start` and toggle `mode` during RUN: no restart, mode unchanged, strobe count still NUM_SAMPLES.
